naive_bus_arbiter_2to1: RTL and testbench



---
 rtl/naive_bus_arbiter_2to1.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_naive_bus_arbiter_2to1.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/naive_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// naive_bus_arbiter_2to1
//
// Lets two naive_bus masters share one naive_bus slave port. Master 0 is the
// core's instruction master and master 1 is its data master. Each cycle one
// master is selected, and that selection is held until the slave grants.
// Grants are routed back to the selected master only. Read data is returned to
// whichever master was granted a read in the previous cycle.
//
// Handshake (all ports): a master raises req together with its addr/data/be
// and holds all of them stable until it sees gnt. A transfer completes in the
// cycle where req and gnt are both high. gnt is combinational in that same
// cycle, and rd_data is valid exactly one cycle after rd_gnt.
//
// Arbitration policy is selected by the ARB_ROUND_ROBIN_EN macro:
//   defined     : round-robin. The pointer master wins contention in IDLE, and
//                 the pointer flips after each grant to the pointer master.
//   not defined : fixed priority. Master 1 (data) wins contention in IDLE.
// In both modes, MAX_WAIT (0 disables it) forces a long-waiting master to win
// the next IDLE arbitration.
//
// Parameters:
//   MAX_WAIT        cycles a losing master may wait before forced priority
//                   (0..255, 0 = never force)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   m0_*_i / m0_*_o master 0 (instruction) slave-side naive_bus port
//   m1_*_i / m1_*_o master 1 (data) slave-side naive_bus port
//   s_*_o / s_*_i   shared downstream master-side naive_bus port
//   state_o         FSM state (0 IDLE, 1 HOLD0, 2 HOLD1)
//   rd_owner_o      read-return owner (0 NONE, 1 M0, 2 M1)
//   wait_cnt_o      anti-starvation wait counter
// -----------------------------------------------------------------------------
module naive_bus_arbiter_2to1 #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    // master 0 (instruction side)
    input  logic        m0_rd_req_i,
    output logic        m0_rd_gnt_o,
    input  logic [31:0] m0_rd_addr_i,
    output logic [31:0] m0_rd_data_o,
    input  logic        m0_wr_req_i,
    output logic        m0_wr_gnt_o,
    input  logic [31:0] m0_wr_addr_i,
    input  logic [31:0] m0_wr_data_i,
    input  logic [3:0]  m0_wr_be_i,

    // master 1 (data side)
    input  logic        m1_rd_req_i,
    output logic        m1_rd_gnt_o,
    input  logic [31:0] m1_rd_addr_i,
    output logic [31:0] m1_rd_data_o,
    input  logic        m1_wr_req_i,
    output logic        m1_wr_gnt_o,
    input  logic [31:0] m1_wr_addr_i,
    input  logic [31:0] m1_wr_data_i,
    input  logic [3:0]  m1_wr_be_i,

    // shared downstream port
    output logic        s_rd_req_o,
    input  logic        s_rd_gnt_i,
    output logic [31:0] s_rd_addr_o,
    input  logic [31:0] s_rd_data_i,
    output logic        s_wr_req_o,
    input  logic        s_wr_gnt_i,
    output logic [31:0] s_wr_addr_o,
    output logic [31:0] s_wr_data_o,
    output logic [3:0]  s_wr_be_o,

    // debug visibility
    output logic [1:0]  state_o,
    output logic [1:0]  rd_owner_o,
    output logic [7:0]  wait_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    // registered state
    state_e     state_q,    state_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wait_id_q,  wait_id_d;   // master tracked by wait_cnt (1 = M1)
`ifdef ARB_ROUND_ROBIN_EN
    logic       rr_ptr_q,   rr_ptr_d;    // 1 = M1 preferred on contention
`endif

    // combinational helpers
    logic req0, req1;
    logic force_en;
    logic pref_m1;
    logic idle_win_m1;
    logic sel_m1;        // selected master, 1 = M1
    logic sel_active;    // selected master currently requests
    logic m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt;
    logic gnt0, gnt1, granted;
    logic eff_id, waiter_req, waiter_gnt;

    assign req0 = m0_rd_req_i | m0_wr_req_i;
    assign req1 = m1_rd_req_i | m1_wr_req_i;

    // Once the waiting master has been held off for MAX_WAIT cycles it takes
    // priority at the next IDLE arbitration. It never breaks a HOLD.
    assign force_en = (MAX_WAIT_L != 8'd0) && (wait_cnt_q >= MAX_WAIT_L);

`ifdef ARB_ROUND_ROBIN_EN
    assign pref_m1 = rr_ptr_q;
`else
    assign pref_m1 = 1'b1;
`endif

    // IDLE winner. A lone requester always wins. With contention, the forced
    // waiter wins, otherwise the policy preference decides.
    assign idle_win_m1 = req1 & (~req0 | (force_en ? wait_id_q : pref_m1));

    // -------------------------------------------------------------------------
    // Selection
    // -------------------------------------------------------------------------
    always_comb begin
        sel_m1 = 1'b0;
        case (state_q)
            IDLE:    sel_m1 = idle_win_m1;
            HOLD0:   sel_m1 = 1'b0;
            HOLD1:   sel_m1 = 1'b1;
            default: sel_m1 = 1'b0;
        endcase
    end

    assign sel_active = sel_m1 ? req1 : req0;

    // -------------------------------------------------------------------------
    // Request forwarding: the selected master drives the slave port, and all
    // fields are zero whenever the selected master is not requesting.
    // -------------------------------------------------------------------------
    always_comb begin
        s_rd_req_o  = 1'b0;
        s_rd_addr_o = 32'h0;
        s_wr_req_o  = 1'b0;
        s_wr_addr_o = 32'h0;
        s_wr_data_o = 32'h0;
        s_wr_be_o   = 4'h0;
        if (sel_active) begin
            if (sel_m1) begin
                s_rd_req_o  = m1_rd_req_i;
                s_rd_addr_o = m1_rd_addr_i;
                s_wr_req_o  = m1_wr_req_i;
                s_wr_addr_o = m1_wr_addr_i;
                s_wr_data_o = m1_wr_data_i;
                s_wr_be_o   = m1_wr_be_i;
            end else begin
                s_rd_req_o  = m0_rd_req_i;
                s_rd_addr_o = m0_rd_addr_i;
                s_wr_req_o  = m0_wr_req_i;
                s_wr_addr_o = m0_wr_addr_i;
                s_wr_data_o = m0_wr_data_i;
                s_wr_be_o   = m0_wr_be_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grant routing. Each grant is also qualified by the master's own req, so a
    // stray slave grant can never reach a master that did not ask for it.
    // -------------------------------------------------------------------------
    assign m0_rd_gnt = ~sel_m1 & m0_rd_req_i & s_rd_gnt_i;
    assign m0_wr_gnt = ~sel_m1 & m0_wr_req_i & s_wr_gnt_i;
    assign m1_rd_gnt =  sel_m1 & m1_rd_req_i & s_rd_gnt_i;
    assign m1_wr_gnt =  sel_m1 & m1_wr_req_i & s_wr_gnt_i;

    assign gnt0    = m0_rd_gnt | m0_wr_gnt;
    assign gnt1    = m1_rd_gnt | m1_wr_gnt;
    assign granted = gnt0 | gnt1;

    assign m0_rd_gnt_o = m0_rd_gnt;
    assign m0_wr_gnt_o = m0_wr_gnt;
    assign m1_rd_gnt_o = m1_rd_gnt;
    assign m1_wr_gnt_o = m1_wr_gnt;

    // -------------------------------------------------------------------------
    // Read return. The slave data passes straight through to the owner of last
    // cycle's read grant, with no extra register on the data path.
    // -------------------------------------------------------------------------
    assign m0_rd_data_o = (rd_owner_q == OWN_M0) ? s_rd_data_i : 32'h0;
    assign m1_rd_data_o = (rd_owner_q == OWN_M1) ? s_rd_data_i : 32'h0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((req0 | req1) && !granted) begin
                    state_d = sel_m1 ? HOLD1 : HOLD0;
                end
            end
            // A dropped req while holding is a protocol violation. It is
            // tolerated by releasing the hold without issuing a grant.
            HOLD0: begin
                if (granted || !req0) begin
                    state_d = IDLE;
                end
            end
            HOLD1: begin
                if (granted || !req1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (m0_rd_gnt) begin
            rd_owner_d = OWN_M0;
        end else if (m1_rd_gnt) begin
            rd_owner_d = OWN_M1;
        end
    end

    // Wait counter. While the count is zero, it follows whichever master lost
    // this cycle. Once the count is running, it keeps tracking that same
    // master until that master is granted or drops its req. That way the
    // forced grant clears the count instead of starting a new count for the
    // master that lost the forced cycle.
    always_comb begin
        eff_id     = (wait_cnt_q == 8'd0) ? ~sel_m1 : wait_id_q;
        waiter_req = eff_id ? req1 : req0;
        waiter_gnt = eff_id ? gnt1 : gnt0;
        wait_id_d  = eff_id;
        wait_cnt_d = wait_cnt_q;
        if (!waiter_req || waiter_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (eff_id != sel_m1) begin
            if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (granted && (sel_m1 == rr_ptr_q)) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_owner_q <= OWN_NONE;
            wait_cnt_q <= 8'd0;
            wait_id_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            wait_cnt_q <= wait_cnt_d;
            wait_id_q  <= wait_id_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign state_o    = state_q;
    assign rd_owner_o = rd_owner_q;
    assign wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_naive_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_naive_bus_arbiter_2to1
//
// Self-checking bench for naive_bus_arbiter_2to1. A table of single-cycle
// vectors covers single-master traffic, write-then-read, and the HOLD corner.
// Hand-written sequences cover contention and a reset during a read.
// Read-return data is checked through an expected queue. One entry is pushed
// per cycle and popped in the following cycle.
// Works with or without ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_naive_bus_arbiter_2to1;

    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] RD_KEY   = 32'h5A5A_0000;
    localparam logic [1:0]  SEL_NONE = 2'd0, SEL_M0 = 2'd1, SEL_M1 = 2'd2;
    localparam logic [1:0]  ST_IDLE  = 2'd0, ST_HOLD0 = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        m0_rd_req, m0_rd_gnt, m0_wr_req, m0_wr_gnt;
    logic [31:0] m0_rd_addr, m0_rd_data, m0_wr_addr, m0_wr_data;
    logic [3:0]  m0_wr_be;
    logic        m1_rd_req, m1_rd_gnt, m1_wr_req, m1_wr_gnt;
    logic [31:0] m1_rd_addr, m1_rd_data, m1_wr_addr, m1_wr_data;
    logic [3:0]  m1_wr_be;
    logic        s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
    logic [31:0] s_rd_addr, s_rd_data, s_wr_addr, s_wr_data;
    logic [3:0]  s_wr_be;
    logic [1:0]  state, rd_owner;
    logic [7:0]  wait_cnt;

    naive_bus_arbiter_2to1 #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_rd_req_i  (m0_rd_req),
        .m0_rd_gnt_o  (m0_rd_gnt),
        .m0_rd_addr_i (m0_rd_addr),
        .m0_rd_data_o (m0_rd_data),
        .m0_wr_req_i  (m0_wr_req),
        .m0_wr_gnt_o  (m0_wr_gnt),
        .m0_wr_addr_i (m0_wr_addr),
        .m0_wr_data_i (m0_wr_data),
        .m0_wr_be_i   (m0_wr_be),
        .m1_rd_req_i  (m1_rd_req),
        .m1_rd_gnt_o  (m1_rd_gnt),
        .m1_rd_addr_i (m1_rd_addr),
        .m1_rd_data_o (m1_rd_data),
        .m1_wr_req_i  (m1_wr_req),
        .m1_wr_gnt_o  (m1_wr_gnt),
        .m1_wr_addr_i (m1_wr_addr),
        .m1_wr_data_i (m1_wr_data),
        .m1_wr_be_i   (m1_wr_be),
        .s_rd_req_o   (s_rd_req),
        .s_rd_gnt_i   (s_rd_gnt),
        .s_rd_addr_o  (s_rd_addr),
        .s_rd_data_i  (s_rd_data),
        .s_wr_req_o   (s_wr_req),
        .s_wr_gnt_i   (s_wr_gnt),
        .s_wr_addr_o  (s_wr_addr),
        .s_wr_data_o  (s_wr_data),
        .s_wr_be_o    (s_wr_be),
        .state_o      (state),
        .rd_owner_o   (rd_owner),
        .wait_cnt_o   (wait_cnt)
    );

    // ---------------- slave model ----------------
    // Grants whatever is requested when enabled. Returns stored write data, or
    // addr ^ RD_KEY for locations never written, one cycle after rd_gnt.
    logic        slv_rd_ok, slv_wr_ok, mem_clear;
    logic [31:0] slv_mem [256];
    logic        slv_vld [256];

    assign s_rd_gnt = s_rd_req & slv_rd_ok;
    assign s_wr_gnt = s_wr_req & slv_wr_ok;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) slv_vld[i] <= 1'b0;
            s_rd_data <= 32'h0;
        end else begin
            if (s_wr_gnt) begin
                slv_mem[s_wr_addr[9:2]] <= s_wr_data;
                slv_vld[s_wr_addr[9:2]] <= 1'b1;
            end
            if (s_rd_gnt)
                s_rd_data <= slv_vld[s_rd_addr[9:2]] ? slv_mem[s_rd_addr[9:2]] : (s_rd_addr ^ RD_KEY);
            else
                s_rd_data <= 32'hB0B0_0001;
        end
    end

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        string       name;
        logic [3:0]  req;      // {m0_rd, m0_wr, m1_rd, m1_wr}
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  be0, be1;
        logic        rd_ok, wr_ok;
        logic [3:0]  gnt;      // {m0_rd, m0_wr, m1_rd, m1_wr}
        logic [1:0]  sel;
        logic [1:0]  st;
        logic [7:0]  wt;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];     // {m0_rd_data, m1_rd_data} expected next cycle
    logic [31:0] exp_mem [256];
    logic        exp_vld [256];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic vec_t mk(input string nm, input logic [3:0] req,
                                input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] be0,
                                input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] be1,
                                input logic rd_ok, input logic wr_ok, input logic [3:0] gnt,
                                input logic [1:0] sel, input logic [1:0] st, input logic [7:0] wt);
        vec_t v;
        v.name = nm; v.req = req;
        v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.rd_ok = rd_ok; v.wr_ok = wr_ok;
        v.gnt = gnt; v.sel = sel; v.st = st; v.wt = wt;
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_vld[a[9:2]] ? exp_mem[a[9:2]] : (a ^ RD_KEY);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        m0_rd_req = 0; m0_wr_req = 0; m0_rd_addr = 0; m0_wr_addr = 0; m0_wr_data = 0; m0_wr_be = 0;
        m1_rd_req = 0; m1_wr_req = 0; m1_rd_addr = 0; m1_wr_addr = 0; m1_wr_data = 0; m1_wr_be = 0;
        slv_rd_ok = 1'b1; slv_wr_ok = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        #4;
        chk("reset.state",    64'(state),      64'(ST_IDLE));
        chk("reset.rd_owner", 64'(rd_owner),   64'd0);
        chk("reset.wait_cnt", 64'(wait_cnt),   64'd0);
        chk("reset.rd_data",  {m0_rd_data, m1_rd_data}, 64'd0);
        chk("reset.gnt",      64'({m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one cycle of stimulus, checks everything that is combinational
    // in that cycle, and checks last cycle's read return.
    task automatic run_vec(input vec_t v);
        logic [63:0] e_rd;
        logic        e_rreq, e_wreq;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_be;
        @(posedge clk); #1;
        // A master that is not requesting drives junk on its fields, so any
        // leak onto the slave port shows up.
        m0_rd_req = v.req[3]; m0_wr_req = v.req[2];
        m1_rd_req = v.req[1]; m1_wr_req = v.req[0];
        if (v.req[3:2] != 2'b00) begin
            m0_rd_addr = v.a0; m0_wr_addr = v.a0; m0_wr_data = v.d0; m0_wr_be = v.be0;
        end else begin
            m0_rd_addr = $urandom; m0_wr_addr = $urandom; m0_wr_data = $urandom;
            m0_wr_be = 4'($urandom_range(0, 15));
        end
        if (v.req[1:0] != 2'b00) begin
            m1_rd_addr = v.a1; m1_wr_addr = v.a1; m1_wr_data = v.d1; m1_wr_be = v.be1;
        end else begin
            m1_rd_addr = $urandom; m1_wr_addr = $urandom; m1_wr_data = $urandom;
            m1_wr_be = 4'($urandom_range(0, 15));
        end
        slv_rd_ok = v.rd_ok; slv_wr_ok = v.wr_ok;
        #4;
        e_rreq = 1'b0; e_wreq = 1'b0; e_addr = 32'h0; e_data = 32'h0; e_be = 4'h0;
        if (v.sel == SEL_M0) begin
            e_rreq = v.req[3]; e_wreq = v.req[2]; e_addr = v.a0; e_data = v.d0; e_be = v.be0;
        end else if (v.sel == SEL_M1) begin
            e_rreq = v.req[1]; e_wreq = v.req[0]; e_addr = v.a1; e_data = v.d1; e_be = v.be1;
        end
        chk({v.name, ".gnt"},      64'({m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt}), 64'(v.gnt));
        chk({v.name, ".state"},    64'(state),     64'(v.st));
        chk({v.name, ".wait_cnt"}, 64'(wait_cnt),  64'(v.wt));
        chk({v.name, ".s_reqs"},   64'({s_rd_req, s_wr_req}), 64'({e_rreq, e_wreq}));
        chk({v.name, ".s_rd_addr"}, 64'(s_rd_addr), 64'(e_addr));
        chk({v.name, ".s_wr_addr"}, 64'(s_wr_addr), 64'(e_addr));
        chk({v.name, ".s_wr_data"}, 64'(s_wr_data), 64'(e_data));
        chk({v.name, ".s_wr_be"},   64'(s_wr_be),   64'(e_be));
        e_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        chk({v.name, ".rd_data"},  {m0_rd_data, m1_rd_data}, e_rd);
        // expectation for next cycle's read return, then the write effect
        if (v.gnt[3])      exp_q.push_back({exp_rd(v.a0), 32'h0});
        else if (v.gnt[1]) exp_q.push_back({32'h0, exp_rd(v.a1)});
        else               exp_q.push_back(64'd0);
        if (v.gnt[2]) begin exp_mem[v.a0[9:2]] = v.d0; exp_vld[v.a0[9:2]] = 1'b1; end
        if (v.gnt[0]) begin exp_mem[v.a1[9:2]] = v.d1; exp_vld[v.a1[9:2]] = 1'b1; end
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t       v;
        logic [7:0] e_cnt;
        logic       e_ptr, win_m1;

        rst_n = 1'b0;
        mem_clear = 1'b1;
        clear_inputs();
        for (int i = 0; i < 256; i++) exp_vld[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;

        //             name          req      a0        d0            be0   a1       d1            be1   rdok wrok gnt      sel       state     wait
        vecs.push_back(mk("idle0",     4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));
        vecs.push_back(mk("m0_rd",     4'b1000, 32'h100,  32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b1000, SEL_M0,   ST_IDLE,  8'd0));
        vecs.push_back(mk("m0_ret",    4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));
        vecs.push_back(mk("m1_wr",     4'b0001, 32'h0,    32'h0,        4'h0, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 1, 4'b0001, SEL_M1,   ST_IDLE,  8'd0));
        vecs.push_back(mk("m0_rd2000", 4'b1000, 32'h2000, 32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b1000, SEL_M0,   ST_IDLE,  8'd0));
        vecs.push_back(mk("wr_rd_ret", 4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));
        vecs.push_back(mk("hold_c1",   4'b1000, 32'h104,  32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 0, 1, 4'b0000, SEL_M0,   ST_IDLE,  8'd0));
        vecs.push_back(mk("hold_c2",   4'b1010, 32'h104,  32'h0,        4'h0, 32'h108, 32'h0,        4'h0, 0, 1, 4'b0000, SEL_M0,   ST_HOLD0, 8'd0));
        vecs.push_back(mk("hold_c3",   4'b1010, 32'h104,  32'h0,        4'h0, 32'h108, 32'h0,        4'h0, 0, 1, 4'b0000, SEL_M0,   ST_HOLD0, 8'd1));
        vecs.push_back(mk("hold_c4",   4'b1010, 32'h104,  32'h0,        4'h0, 32'h108, 32'h0,        4'h0, 1, 1, 4'b1000, SEL_M0,   ST_HOLD0, 8'd2));
        vecs.push_back(mk("hold_c5",   4'b0010, 32'h0,    32'h0,        4'h0, 32'h108, 32'h0,        4'h0, 1, 1, 4'b0010, SEL_M1,   ST_IDLE,  8'd3));
        vecs.push_back(mk("hold_ret",  4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));
        vecs.push_back(mk("m0_rdwr",   4'b1100, 32'h10C,  32'h12345678, 4'h3, 32'h0,   32'h0,        4'h0, 1, 0, 4'b1000, SEL_M0,   ST_IDLE,  8'd0));
        vecs.push_back(mk("rdwr_ret",  4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));
        vecs.push_back(mk("m0_wr_be",  4'b0100, 32'h110,  32'hCAFEF00D, 4'h5, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0100, SEL_M0,   ST_IDLE,  8'd0));
        vecs.push_back(mk("idle_end",  4'b0000, 32'h0,    32'h0,        4'h0, 32'h0,   32'h0,        4'h0, 1, 1, 4'b0000, SEL_NONE, ST_IDLE,  8'd0));

        // table section
        do_reset();
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // contention: both masters read every cycle, slave always grants
        do_reset();
        e_cnt = 8'd0;
        e_ptr = 1'b1;
        for (int k = 0; k < 34; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_m1 = (e_cnt >= 8'(MAX_WAIT)) ? 1'b0 : e_ptr;
`else
            win_m1 = (e_cnt >= 8'(MAX_WAIT)) ? 1'b0 : 1'b1;
`endif
            v = mk($sformatf("cont%0d", k), 4'b1010,
                   32'h600 + 32'(4 * (k % 8)), 32'h0, 4'h0,
                   32'h700 + 32'(4 * (k % 8)), 32'h0, 4'h0,
                   1, 1, win_m1 ? 4'b0010 : 4'b1000,
                   win_m1 ? SEL_M1 : SEL_M0, ST_IDLE, e_cnt);
            run_vec(v);
            if (win_m1) e_cnt = (e_cnt == 8'hFF) ? e_cnt : e_cnt + 8'd1;
            else        e_cnt = 8'd0;
            if (win_m1 == e_ptr) e_ptr = ~e_ptr;
        end

        // reset in the cycle after a read grant: pending data is dropped
        do_reset();
        run_vec(mk("rst_rd", 4'b1000, 32'h104, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                   1, 1, 4'b1000, SEL_M0, ST_IDLE, 8'd0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        #4;
        chk("midrst.rd_owner", 64'(rd_owner), 64'd0);
        chk("midrst.rd_data",  {m0_rd_data, m1_rd_data}, 64'd0);
        chk("midrst.state",    64'(state), 64'(ST_IDLE));
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        run_vec(mk("after_rst", 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                   1, 1, 4'b0000, SEL_NONE, ST_IDLE, 8'd0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
